// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_pkg
//  Shared CPU definitions: hazard tracking entry, register-zero constant,
//  forwarding select encoding and the "is a live register writer" helper.
//  Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Tracking entries store register addresses at the widest supported width;
   // narrower address buses are zero-extended on entry.
   localparam int HZ_ADDR_W = 8;

   typedef struct packed {
      logic                 valid;
      logic [HZ_ADDR_W-1:0] waddr;
      logic                 reg_write;
      logic                 mem_read;
   } hz_entry_t;

   localparam logic [HZ_ADDR_W-1:0] REG_ZERO = '0;

   // fwd_sel encoding: 0 = operand from ID/EX, k = result held by entry k
   localparam int FWD_REG = 0;
   localparam int FWD_MEM = 1;
   localparam int FWD_WB  = 2;

   // An entry only matters for hazards if it will really write a register;
   // register 0 is hard-wired and never produces a dependency.
   function automatic logic hz_writer(input hz_entry_t e);
      return e.valid & e.reg_write & (e.waddr != REG_ZERO);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  pipe_hazard_ctrl_if
//  Bundle between the pipeline datapath (master) and the hazard controller
//  (slave): ID-stage decode info, redirect, and the stall/flush/forward
//  controls returned to the pipeline registers and operand muxes.
//  Revision: 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int N_TRACK    = 3
);
   localparam int SEL_W = $clog2(N_TRACK);

   logic                  enable;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_use_rs;
   logic                  id_use_rt;
   logic [REG_ADDR_W-1:0] id_waddr;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  br_taken;

   logic                  stall;
   logic                  bubble_id_ex;
   logic                  flush_if_id;
   logic [N_TRACK-1:0]    kill;
   logic [SEL_W-1:0]      fwd_sel_a;
   logic [SEL_W-1:0]      fwd_sel_b;
   logic                  id_byp_a;
   logic                  id_byp_b;
   logic [N_TRACK-1:0]    stage_valid;

   modport master (
      output enable, id_rs, id_rt, id_use_rs, id_use_rt, id_waddr,
             id_reg_write, id_mem_read, br_taken,
      input  stall, bubble_id_ex, flush_if_id, kill, fwd_sel_a, fwd_sel_b,
             id_byp_a, id_byp_b, stage_valid
   );

   modport slave (
      input  enable, id_rs, id_rt, id_use_rs, id_use_rt, id_waddr,
             id_reg_write, id_mem_read, br_taken,
      output stall, bubble_id_ex, flush_if_id, kill, fwd_sel_a, fwd_sel_b,
             id_byp_a, id_byp_b, stage_valid
   );
endinterface
`default_nettype wire

// File: rtl/hz_match.sv
`default_nettype none
// ============================================================================
//  hz_match
//  Combinational priority encoder: youngest (lowest index) candidate entry
//  whose destination matches one source operand.
//  Revision: 1.0 - initial release
// ============================================================================
module hz_match #(
   parameter int N_TRACK = 3,
   parameter int SEL_W   = 2,
   parameter int ADDR_W  = 8
) (
   input  wire logic [ADDR_W-1:0]              i_src,
   input  wire logic                           i_use,
   input  wire logic [N_TRACK-1:0]             i_cand,
   input  wire logic [N_TRACK-1:0][ADDR_W-1:0] i_waddr,
   output      logic                           o_hit,
   output      logic [SEL_W-1:0]               o_idx
);

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int k = N_TRACK - 1; k >= 0; k--) begin
         if (i_use && i_cand[k] && (i_waddr[k] == i_src)) begin
            o_hit = 1'b1;
            o_idx = SEL_W'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  pipe_hazard_ctrl
//  Hazard, forwarding and flush controller. Tracks destination state for
//  every in-flight instruction from EX (entry 0) to WB (entry N_TRACK-1),
//  raises load-use / RAW stalls, redirect flushes, EX forwarding selects and
//  ID regfile bypass flags.
//  Build option: HAZ_FWD_EN - defined: full forwarding, load-use stall only;
//                undefined: pure interlock, forwarding selects tied to 0.
//  Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int N_TRACK    = 3,
   parameter int BR_STAGE   = 1
) (
   input wire logic         clk,
   input wire logic         arst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int SEL_W = $clog2(N_TRACK);

   hz_entry_t [N_TRACK-1:0]                r_ent;
   logic [N_TRACK-1:0]                     w_writer;
   logic [N_TRACK-1:0][HZ_ADDR_W-1:0]      w_waddr;
   logic [N_TRACK-1:0]                     w_kill;
   logic [N_TRACK-1:0]                     w_valid;
   logic [N_TRACK-1:0]                     w_cand;
   logic [HZ_ADDR_W-1:0]                   w_id_rs;
   logic [HZ_ADDR_W-1:0]                   w_id_rt;
   logic [HZ_ADDR_W-1:0]                   w_id_waddr;
   logic [HZ_ADDR_W-1:0]                   w_src_a;
   logic [HZ_ADDR_W-1:0]                   w_src_b;
   logic                                   w_use_a;
   logic                                   w_use_b;
   logic                                   w_hit_a;
   logic                                   w_hit_b;
   logic [SEL_W-1:0]                       w_idx_a;
   logic [SEL_W-1:0]                       w_idx_b;
   logic                                   w_haz;
   logic                                   w_stall;
   logic                                   w_inject;
   logic [SEL_W-1:0]                       w_fwd_a;
   logic [SEL_W-1:0]                       w_fwd_b;

   assign w_id_rs    = HZ_ADDR_W'(bus.id_rs);
   assign w_id_rt    = HZ_ADDR_W'(bus.id_rt);
   assign w_id_waddr = HZ_ADDR_W'(bus.id_waddr);

   // Per-entry decode: live writers, their addresses, valid and kill vectors.
   always_comb begin
      w_writer = '0;
      w_waddr  = '0;
      w_valid  = '0;
      w_kill   = '0;
      for (int k = 0; k < N_TRACK; k++) begin
         w_writer[k] = hz_writer(r_ent[k]);
         w_waddr[k]  = r_ent[k].waddr;
         w_valid[k]  = r_ent[k].valid;
         w_kill[k]   = bus.br_taken && (k < BR_STAGE);
      end
   end

`ifdef HAZ_FWD_EN
   logic [REG_ADDR_W-1:0] r_rs;
   logic [REG_ADDR_W-1:0] r_rt;
   logic                  r_use_rs;
   logic                  r_use_rt;
   logic                  w_load_use;

   // EX consumer sources, captured as the instruction enters entry 0.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_rs     <= '0;
         r_rt     <= '0;
         r_use_rs <= 1'b0;
         r_use_rt <= 1'b0;
      end else if (bus.enable) begin
         r_rs     <= w_inject ? '0   : bus.id_rs;
         r_rt     <= w_inject ? '0   : bus.id_rt;
         r_use_rs <= w_inject ? 1'b0 : bus.id_use_rs;
         r_use_rt <= w_inject ? 1'b0 : bus.id_use_rt;
      end
   end

   assign w_src_a = HZ_ADDR_W'(r_rs);
   assign w_src_b = HZ_ADDR_W'(r_rt);
   assign w_use_a = r_use_rs;
   assign w_use_b = r_use_rt;

   // Forwarding candidates: entries from MEM onward, excluding a load whose
   // data is not yet available (still before WB).
   always_comb begin
      w_cand = '0;
      for (int k = 0; k < N_TRACK; k++) begin
         w_cand[k] = w_writer[k] && (k >= FWD_MEM) &&
                     !(r_ent[k].mem_read && (k < FWD_WB));
      end
   end

   assign w_load_use = w_writer[0] && r_ent[0].mem_read &&
                       ((bus.id_use_rs && (w_id_rs == w_waddr[0])) ||
                        (bus.id_use_rt && (w_id_rt == w_waddr[0])));
   assign w_haz   = w_load_use;
   assign w_fwd_a = w_hit_a ? w_idx_a : SEL_W'(FWD_REG);
   assign w_fwd_b = w_hit_b ? w_idx_b : SEL_W'(FWD_REG);
`else
   logic w_unused_idx;

   assign w_src_a = w_id_rs;
   assign w_src_b = w_id_rt;
   assign w_use_a = bus.id_use_rs;
   assign w_use_b = bus.id_use_rt;

   // Interlock candidates: every writer not yet in WB (WB is covered by the
   // ID bypass).
   always_comb begin
      w_cand = '0;
      for (int k = 0; k < N_TRACK; k++) begin
         w_cand[k] = w_writer[k] && (k < N_TRACK - 1);
      end
   end

   assign w_haz        = w_hit_a | w_hit_b;
   assign w_fwd_a      = SEL_W'(FWD_REG);
   assign w_fwd_b      = SEL_W'(FWD_REG);
   assign w_unused_idx = ^{w_idx_a, w_idx_b};
`endif

   hz_match #(.N_TRACK(N_TRACK), .SEL_W(SEL_W), .ADDR_W(HZ_ADDR_W)) u_match_a (
      .i_src   (w_src_a),
      .i_use   (w_use_a),
      .i_cand  (w_cand),
      .i_waddr (w_waddr),
      .o_hit   (w_hit_a),
      .o_idx   (w_idx_a)
   );

   hz_match #(.N_TRACK(N_TRACK), .SEL_W(SEL_W), .ADDR_W(HZ_ADDR_W)) u_match_b (
      .i_src   (w_src_b),
      .i_use   (w_use_b),
      .i_cand  (w_cand),
      .i_waddr (w_waddr),
      .o_hit   (w_hit_b),
      .o_idx   (w_idx_b)
   );

   // Redirect overrides any stall; either one injects a bubble into entry 0.
   assign w_stall  = w_haz & ~bus.br_taken;
   assign w_inject = w_stall | bus.br_taken;

   // Advance the tracking pipe; redirect clears the younger entries first.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_ent <= '0;
      end else if (bus.enable) begin
         if (w_inject) begin
            r_ent[0] <= '0;
         end else begin
            r_ent[0] <= '{valid:     1'b1,
                          waddr:     w_id_waddr,
                          reg_write: bus.id_reg_write,
                          mem_read:  bus.id_mem_read};
         end
         for (int k = 1; k < N_TRACK; k++) begin
            r_ent[k] <= r_ent[k-1];
            if (bus.br_taken && ((k - 1) < BR_STAGE)) begin
               r_ent[k].valid <= 1'b0;
            end
         end
      end
   end

   assign bus.stall        = w_stall;
   assign bus.bubble_id_ex = w_inject;
   assign bus.flush_if_id  = bus.br_taken;
   assign bus.kill         = w_kill;
   assign bus.fwd_sel_a    = w_fwd_a;
   assign bus.fwd_sel_b    = w_fwd_b;
   assign bus.id_byp_a     = w_writer[N_TRACK-1] && bus.id_use_rs &&
                             (w_id_rs == w_waddr[N_TRACK-1]);
   assign bus.id_byp_b     = w_writer[N_TRACK-1] && bus.id_use_rt &&
                             (w_id_rt == w_waddr[N_TRACK-1]);
   assign bus.stage_valid  = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_pipe_hazard_ctrl
//  Directed bench for pipe_hazard_ctrl (N_TRACK=3, BR_STAGE=1). Expected
//  values follow the build: HAZ_FWD_EN selects forwarding expectations.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int REG_ADDR_W = 5;
   localparam int N_TRACK    = 3;
   localparam int BR_STAGE   = 1;
`ifdef HAZ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .N_TRACK(N_TRACK)) bus ();

   pipe_hazard_ctrl #(
      .REG_ADDR_W (REG_ADDR_W),
      .N_TRACK    (N_TRACK),
      .BR_STAGE   (BR_STAGE)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [4:0] wa, input logic rw, input logic mr);
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.id_use_rs    = urs;
      bus.id_use_rt    = urt;
      bus.id_waddr     = wa;
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
   endtask

   task automatic op_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      set_id(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
   endtask

   task automatic op_lw(input logic [4:0] rd, input logic [4:0] base);
      set_id(base, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
   endtask

   task automatic op_beq(input logic [4:0] rs, input logic [4:0] rt);
      set_id(rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic op_nop();
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      op_nop();
      repeat (N_TRACK) tick();
   endtask

   // Consumer held in ID: expect n stall+bubble cycles, then release.
   task automatic expect_stall(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_stall"}, 32'(bus.stall), 32'd1);
         check({tag, "_bubble"}, 32'(bus.bubble_id_ex), 32'd1);
         tick();
      end
      check({tag, "_release"}, 32'(bus.stall), 32'd0);
      check({tag, "_no_bubble"}, 32'(bus.bubble_id_ex), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.enable   = 1'b1;
      bus.br_taken = 1'b0;
      op_nop();
      #3;
      check("rst_stall",  32'(bus.stall),        32'd0);
      check("rst_bubble", 32'(bus.bubble_id_ex), 32'd0);
      check("rst_flush",  32'(bus.flush_if_id),  32'd0);
      check("rst_kill",   32'(bus.kill),         32'd0);
      check("rst_fwd_a",  32'(bus.fwd_sel_a),    32'd0);
      check("rst_fwd_b",  32'(bus.fwd_sel_b),    32'd0);
      check("rst_byp_a",  32'(bus.id_byp_a),     32'd0);
      check("rst_valid",  32'(bus.stage_valid),  32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      tick();

      // add r3,r1,r2 ; sub r4,r3,r5
      op_add(5'd3, 5'd1, 5'd2); #1;
      check("t1_prod_stall", 32'(bus.stall), 32'd0);
      tick();
      op_add(5'd4, 5'd3, 5'd5); #1;
      expect_stall("t1", FWD ? 0 : 2);
      check("t1_byp_a", 32'(bus.id_byp_a), FWD ? 32'd0 : 32'd1);
      tick();
      op_nop(); #1;
      check("t1_fwd_a", 32'(bus.fwd_sel_a), FWD ? 32'd1 : 32'd0);
      check("t1_fwd_b", 32'(bus.fwd_sel_b), 32'd0);
      drain();

      // add r3 ; nop ; sub r4,r3,r5
      op_add(5'd3, 5'd1, 5'd2); #1;
      tick();
      op_nop(); #1;
      tick();
      op_add(5'd4, 5'd3, 5'd5); #1;
      expect_stall("t1b", FWD ? 0 : 1);
      check("t1b_byp_a", 32'(bus.id_byp_a), FWD ? 32'd0 : 32'd1);
      tick();
      op_nop(); #1;
      check("t1b_fwd_a", 32'(bus.fwd_sel_a), FWD ? 32'd2 : 32'd0);
      drain();

      // lw r3,0(r0) ; add r4,r3,r3
      op_lw(5'd3, 5'd0); #1;
      check("t2_lw_stall", 32'(bus.stall), 32'd0);
      tick();
      op_add(5'd4, 5'd3, 5'd3); #1;
      expect_stall("t2", FWD ? 1 : 2);
      check("t2_byp_a", 32'(bus.id_byp_a), FWD ? 32'd0 : 32'd1);
      check("t2_byp_b", 32'(bus.id_byp_b), FWD ? 32'd0 : 32'd1);
      tick();
      op_nop(); #1;
      check("t2_fwd_a", 32'(bus.fwd_sel_a), FWD ? 32'd2 : 32'd0);
      check("t2_fwd_b", 32'(bus.fwd_sel_b), FWD ? 32'd2 : 32'd0);
      drain();

      // add r0,r1,r2 ; add r4,r0,r0  (register zero never a dependency)
      op_add(5'd0, 5'd1, 5'd2); #1;
      tick();
      op_add(5'd4, 5'd0, 5'd0); #1;
      check("t3_stall", 32'(bus.stall), 32'd0);
      check("t3_byp_a", 32'(bus.id_byp_a), 32'd0);
      tick();
      op_nop(); #1;
      check("t3_fwd_a", 32'(bus.fwd_sel_a), 32'd0);
      check("t3_fwd_b", 32'(bus.fwd_sel_b), 32'd0);
      op_add(5'd0, 5'd1, 5'd2); tick();
      op_nop(); tick();
      tick();
      op_add(5'd4, 5'd0, 5'd0); #1;
      check("t3_byp_wb_a", 32'(bus.id_byp_a), 32'd0);
      check("t3_byp_wb_b", 32'(bus.id_byp_b), 32'd0);
      drain();

      // beq (MEM) taken while lw-use stall pending
      op_beq(5'd1, 5'd2); #1;
      tick();
      op_lw(5'd3, 5'd0); #1;
      tick();
      op_add(5'd4, 5'd3, 5'd3);
      bus.br_taken = 1'b1; #1;
      check("t4_flush",  32'(bus.flush_if_id),  32'd1);
      check("t4_kill",   32'(bus.kill),         32'b001);
      check("t4_stall",  32'(bus.stall),        32'd0);
      check("t4_bubble", 32'(bus.bubble_id_ex), 32'd1);
      tick();
      bus.br_taken = 1'b0;
      op_nop(); #1;
      check("t4_valid",     32'(bus.stage_valid), 32'b100);
      check("t4_flush_off", 32'(bus.flush_if_id), 32'd0);
      check("t4_kill_off",  32'(bus.kill),        32'd0);
      drain();

      // Three valid writers r7/r6/r5 in EX/MEM/WB, consumer add r9,r5,r7
      op_add(5'd5, 5'd1, 5'd2); tick();
      op_add(5'd6, 5'd1, 5'd2); tick();
      op_add(5'd7, 5'd1, 5'd2); tick();
      op_add(5'd9, 5'd5, 5'd7); #1;
      check("t5_valid", 32'(bus.stage_valid), 32'b111);
      check("t5_byp_a", 32'(bus.id_byp_a),    32'd1);
      check("t5_byp_b", 32'(bus.id_byp_b),    32'd0);
      check("t5_stall", 32'(bus.stall),       FWD ? 32'd0 : 32'd1);
      bus.enable = 1'b0;
      repeat (5) tick();
      check("t5_hold_valid", 32'(bus.stage_valid), 32'b111);
      check("t5_hold_byp_a", 32'(bus.id_byp_a),    32'd1);
      check("t5_hold_stall", 32'(bus.stall),       FWD ? 32'd0 : 32'd1);
      #2;
      arst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.stage_valid), 32'd0);
      check("t5_rst_stall", 32'(bus.stall),       32'd0);
      check("t5_rst_byp_a", 32'(bus.id_byp_a),    32'd0);
      check("t5_rst_fwd_a", 32'(bus.fwd_sel_a),   32'd0);
      bus.enable = 1'b1;
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check("t5_rel_valid", 32'(bus.stage_valid), 32'd0);
      tick();
      check("t5_first_valid", 32'(bus.stage_valid), 32'b001);
      check("t5_first_byp_a", 32'(bus.id_byp_a),    32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
